// File: rtl/id_queue_if.sv
// Handshake bundle between fetch, the decode queue and execute.
interface id_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]     inst_i;
  logic [XLEN-1:0] inst_addr_i;
  logic            inst_valid_i;
  logic            inst_ready_o;
  logic            ex_jump_flag_i;
  logic            ex_ready_i;
  logic            issue_valid_o;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] inst_addr_o;
  logic [4:0]      rs1_o, rs2_o, rd_o;
  logic            reg1_re_o, reg2_re_o, reg_we_o;
  logic [31:0]     imm_o;
  logic            is_load_o, is_branch_o, illegal_o;
  logic [CW-1:0]   count_o;

  modport slave (
    input  inst_i, inst_addr_i, inst_valid_i, ex_jump_flag_i, ex_ready_i,
    output inst_ready_o, issue_valid_o, inst_o, inst_addr_o, rs1_o, rs2_o, rd_o,
           reg1_re_o, reg2_re_o, reg_we_o, imm_o, is_load_o, is_branch_o,
           illegal_o, count_o
  );

  modport master (
    output inst_i, inst_addr_i, inst_valid_i, ex_jump_flag_i, ex_ready_i,
    input  inst_ready_o, issue_valid_o, inst_o, inst_addr_o, rs1_o, rs2_o, rd_o,
           reg1_re_o, reg2_re_o, reg_we_o, imm_o, is_load_o, is_branch_o,
           illegal_o, count_o
  );
endinterface

// File: rtl/id_queue.sv
// Decode queue: buffers fetched instructions, pre-decodes the head,
// applies a one-cycle load-use interlock and flushes on jump.
module id_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic     clk,
  input logic     rst,
  id_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     mem_inst [DEPTH];
  logic [XLEN-1:0] mem_addr [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            ld_v;
  logic [4:0]      ld_rd;

  logic        empty, full, flush, enq, deq, stall;
  logic [31:0] head;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        re1, re2, we, ld, br, ill;
  logic [31:0] imm;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign flush = bus.ex_jump_flag_i;
  // Empty queue presents an all-zero head so every decoded field reads 0.
  assign head  = empty ? '0 : mem_inst[rptr];
  assign opc   = head[6:0];
  assign f3    = head[14:12];
  assign f7    = head[31:25];

  // Pre-decode of the head entry.
  always_comb begin
    re1 = 1'b0; re2 = 1'b0; we = 1'b0; ld = 1'b0; br = 1'b0; ill = 1'b0;
    imm = '0;
    if (!empty) begin
      case (opc)
        7'b0110011: begin
          if (f7 == 7'b0000000 || f7 == 7'b0100000 || f7 == 7'b0000001) begin
            re1 = 1'b1; re2 = 1'b1; we = 1'b1;
          end else begin
            ill = 1'b1;
          end
        end
        7'b0010011, 7'b1100111: begin
          re1 = 1'b1; we = 1'b1;
          imm = {{20{head[31]}}, head[31:20]};
        end
        7'b0000011: begin
          re1 = 1'b1; we = 1'b1; ld = 1'b1;
          imm = {{20{head[31]}}, head[31:20]};
        end
        7'b0100011: begin
          re1 = 1'b1; re2 = 1'b1;
          imm = {{20{head[31]}}, head[31:25], head[11:7]};
        end
        7'b1100011: begin
          re1 = 1'b1; re2 = 1'b1; br = 1'b1;
          imm = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
        end
        7'b1101111: begin
          we  = 1'b1;
          imm = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          we  = 1'b1;
          imm = {head[31:12], 12'b0};
        end
        7'b1110011: begin
          // funct3=0 is ECALL/EBREAK/xRET: no register traffic.
          if (f3 != 3'b000) begin
            we  = 1'b1;
            re1 = ~f3[2];
            imm = {20'b0, head[31:20]};
          end
        end
        7'b0001111: ;
        default: ill = 1'b1;
      endcase
    end
  end

  assign stall = ld_v & ((re1 & (head[19:15] == ld_rd)) | (re2 & (head[24:20] == ld_rd)));
  assign deq   = bus.issue_valid_o & bus.ex_ready_i;
  assign enq   = bus.inst_valid_i & ~full & ~flush;

  assign bus.inst_ready_o  = ~full;
  assign bus.issue_valid_o = ~empty & ~stall & ~flush;
  assign bus.inst_o        = head;
  assign bus.inst_addr_o   = empty ? '0 : mem_addr[rptr];
  assign bus.rs1_o         = head[19:15];
  assign bus.rs2_o         = head[24:20];
  assign bus.rd_o          = head[11:7];
  assign bus.reg1_re_o     = re1;
  assign bus.reg2_re_o     = re2;
  assign bus.reg_we_o      = we & (head[11:7] != 5'd0);
  assign bus.imm_o         = imm;
  assign bus.is_load_o     = ld;
  assign bus.is_branch_o   = br;
  assign bus.illegal_o     = ill;
  assign bus.count_o       = count;

  // Entry storage; no reset needed since reads are gated by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_inst[wptr] <= bus.inst_i;
      mem_addr[wptr] <= bus.inst_addr_i;
    end
  end

  // Pointers, occupancy and load-use tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ld_v  <= 1'b0;
      ld_rd <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ld_v  <= 1'b0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ld_v  <= deq & ld & (head[11:7] != 5'd0);
      ld_rd <= head[11:7];
    end
  end
endmodule

// File: doc/id_queue.md
# id_queue

Parametrised decode queue between `if_id` and `ex`. It buffers up to DEPTH fetched instructions, pre-decodes the head entry, and issues it to execute under a valid/ready handshake. It adds three things the single-cycle decode path lacks: buffering, a one-cycle load-use interlock, and a flush on `ex_jump_flag_i`. Register-file and CSR reads stay downstream; this block delivers register addresses, read/write enables and the sign-extended immediate.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥2
- `XLEN`, 32, instruction/address width; RV32 only, fixed at 32
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `inst_i`  in  32  instruction from fetch
- `inst_addr_i`  in  XLEN  instruction address
- `inst_valid_i`  in  1  fetch offers an instruction
- `inst_ready_o`  out  1  queue accepts (= not full)
- `ex_jump_flag_i`  in  1  flush: discard all entries this cycle
- `ex_ready_i`  in  1  execute accepts issued instruction
- `issue_valid_o`  out  1  head is valid and not stalled
- `inst_o`, `inst_addr_o`  out  32/XLEN  head instruction and address
- `rs1_o`, `rs2_o`, `rd_o`  out  5 each  register addresses
- `reg1_re_o`, `reg2_re_o`  out  1  head reads rs1 / rs2
- `reg_we_o`  out  1  head writes rd (0 when rd=x0)
- `imm_o`  out  32  sign-extended immediate for head format
- `is_load_o`, `is_branch_o`, `illegal_o`  out  1  class flags
- `count_o`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: circular buffer of {inst, addr}; write pointer, read pointer, count register.
- Enqueue when `inst_valid_i & inst_ready_o & ~ex_jump_flag_i`. `inst_ready_o = (count != DEPTH)`. A full queue refuses enqueue even if a dequeue happens in the same cycle.
- Issue (dequeue) when `issue_valid_o & ex_ready_i`. `issue_valid_o = (count != 0) & ~stall & ~ex_jump_flag_i`.
- Pre-decode of the head, combinational from the stored entry:
  - R/M (0110011): re1, re2, we. Legal funct7 values are 0000000, 0100000 and 0000001; any other funct7 sets illegal.
  - I-ALU (0010011), load (0000011), JALR: re1, we; imm = I-type.
  - Store (0100011): re1, re2; imm = S-type.
  - Branch (1100011): re1, re2; imm = B-type; `is_branch_o`.
  - JAL: we; imm = J-type.
  - LUI/AUIPC: we; imm = {inst[31:12], 12'b0}.
  - CSR (1110011) with funct3≠0: we; re1 only if funct3[2]=0; imm = zero-extended csr address.
  - FENCE and funct3=0 SYSTEM: no reads or writes.
  - Any other opcode: `illegal_o`, all enables 0.
- `reg_we_o` is forced to 0 when rd=0. `rs1_o`/`rs2_o`/`rd_o` are raw fields. All decoded outputs are 0 while the queue is empty.
- Load-use interlock:
  - Register `ld_v`/`ld_rd` loads `issue & is_load_o & rd≠0` each cycle.
  - `stall = ld_v & ((reg1_re_o & rs1_o==ld_rd) | (reg2_re_o & rs2_o==ld_rd))`.
  - The stall lasts exactly one cycle.
- Flush (`ex_jump_flag_i`=1): next cycle count=0, pointers equal, `ld_v`=0. No issue and no enqueue occur in the flush cycle.

## Timing
- Reset (rst=0, async): count=0, pointers=0, `ld_v`=0.
  - Outputs: `inst_ready_o`=1, `issue_valid_o`=0, all decoded fields 0, `count_o`=0.
- Enqueue-to-issue latency: 1 cycle. An instruction written at edge t is at the head and can issue in the cycle after t.
- Simultaneous enqueue and issue (not full): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- Handshake: `issue_valid_o` may drop without a transfer only because of stall or flush. Head contents stay stable while `issue_valid_o & ~ex_ready_i`.
- Reset asserted mid-operation discards all entries immediately.

## Test plan
- Fill/drain, DEPTH=4: with `ex_ready_i`=0, push 5 ADDIs → 4 accepted, `inst_ready_o`=0, `count_o`=4. Set ready → issued in order at 1 per cycle, `count_o` falls to 0.
- Immediate decode: head 0xFE0008E3 (BEQ x0,x0,-16) → re1=re2=1, `is_branch_o`=1, `imm_o`=0xFFFFFFF0. Head 0x800000EF (JAL x1) → `imm_o`=0xFFF00000, `reg_we_o`=1.
- Load-use: LW x5,0(x1) then ADD x6,x5,x7 → ADD held exactly one cycle with `issue_valid_o`=0, then issues. LW x0 followed by a reader of x0 → no stall.
- Flush: 3 entries queued, pulse `ex_jump_flag_i` while `inst_valid_i`=1 → no issue and no enqueue that cycle, `count_o`=0 next cycle, `ld_v` cleared.
- Wrap and simultaneous: ≥10 instructions streamed with `inst_valid_i` and `ex_ready_i` both held high → issue order and addresses match push order, `count_o` constant.
- Illegal: opcode 0x7F, or R-type with funct7=0x10 → `illegal_o`=1, `reg_we_o`=0, still issued. Async reset mid-stream → `issue_valid_o`=0 with no clock edge.
